montgomery_shift_reduce: RTL and testbench
==========================================

# montgomery_shift_reduce

Pipelined Montgomery reduction for NTT-friendly moduli q = qH·2^LOGQH + 1, with qH = 2^LOGQH − 2^K1 − 2^K2 (+ 2^K3). It computes T = C·2^(−LOGQ) mod q. The multiplication by qH is implemented with shifts and adds only; no multipliers are used. The block sits after the coefficient multiplier in the modular-multiplier datapath and accepts one product per cycle.

## Interface
- LOGQ, 64: modulus width; C is 2·LOGQ bits.
- LOGQH, 32: Montgomery word width w. Requires LOGQ = 2·LOGQH, giving two reduction iterations.
- CORRECT, 1: 1 selects a final conditional correction into [0,q). 0 outputs the raw low LOGQ bits of the signed result.
- FF_IN, FF_SHF0, FF_SUB0, FF_SHF1, FF_SUB1, FF_SUM, FF_OUT, each 1: per-stage register enable. 1 registers that stage; 0 makes it combinational.
- USE_K3, 1: 1 includes the +2^K3 term; 0 omits it.
- LOGK1, LOGK2, LOGK3, each 5: widths of the shift-amount inputs.
- LAT (localparam, visible hierarchically) = FF_IN+FF_SHF0+FF_SUB0+FF_SHF1+FF_SUB1+FF_SUM+FF_OUT. The default is 7.
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- qH, in, LOGQH: upper word of q; the full modulus is q = {qH, LOGQH'b0} + 1.
- C, in, 2·LOGQ: value to reduce.
- K1, in, LOGK1: shift amount of the first subtracted term.
- K2, in, LOGK2: shift amount of the second subtracted term.
- K3, in, LOGK3: shift amount of the added term.
- T, out, LOGQ: reduced result.

## Operation
- Preconditions: q is odd with q ≡ 1 mod 2^w, so −q^(−1) mod 2^w = −1. K values are < LOGQH. C < q·2^LOGQ.
- Iteration i (i = 0, 1), starting from X0 = C (signed internal arithmetic, width 2·LOGQ+2):
  - m = X[w−1:0].
  - P = (m<<w) − (m<<K1) − (m<<K2) + (USE_K3 ? m<<K3 : 0). This equals m·qH.
  - X(i+1) = (X >>> w) − P. The result is exact because X − m·q = 2^w·(X>>>w − m·qH).
- Stage mapping:
  - SHF0 forms P for iteration 0; SUB0 forms X1.
  - SHF1 forms P for iteration 1; SUB1 forms X2.
  - SUM forms X2, X2+q and X2−q.
  - OUT selects the result and drives T.
- Correction when CORRECT=1:
  - X2 < 0 → T = X2 + q.
  - X2 ≥ q → T = X2 − q.
  - Otherwise T = X2.
  - T is always in [0,q).
- When CORRECT=0, T = X2[LOGQ−1:0].
- qH and the K values travel down the pipeline with their C. Each datum uses the parameters sampled with it, so the modulus may change on any cycle.
- No handshake or valid signal. Every cycle is a new input.

## Timing
- Latency: C/qH/K values sampled at rising edge n produce T after edge n+LAT−1 when FF_IN=1. Equivalently, T is valid LAT cycles after the input is applied. The default is 7.
- Throughput is one reduction per clock; back-to-back inputs do not interfere.
- Reset (rst=0) asynchronously clears all pipeline registers; T = 0 immediately and while held.
- After release, outputs are 0 until the first real input reaches the output. Zero inputs propagate as T = 0.
- Reset asserted mid-stream flushes all in-flight data. No stale value appears after release.
- With all FF_* = 0, the block is purely combinational and LAT = 0.

## Test plan
- Reference vector: q=0xb040000000000001 (qH=0xb0400000), K1=30, K2=28, K3=22, C=0x7958100000000001607ffffffffffffd, held 1 cycle then zeroed. Required: T=0x2b5fc00000000003 after LAT=7 cycles.
- Same q, C=1 → T=0x7958100000000000 (2^−64 mod q). This exercises negative X2 and the +q correction.
- Same q, C=q·2^64 (X2=q) → T=0. This exercises the −q correction.
- Same q, C=0 → T=0.
- Back-to-back pipeline: apply C=1, the reference C, and C=0 on consecutive cycles → T sequence 0x7958100000000000, 0x2b5fc00000000003, 0 on consecutive cycles starting at LAT.
- Reset: assert rst=0 for 2 cycles with two inputs in flight → T=0 at once and no stale results after release. A fresh reference input afterwards → correct T after LAT cycles.

Source files
------------

// File: rtl/montgomery_shift_reduce.sv
// montgomery_shift_reduce
// ---------------------------------------------------------------------------
// Pipelined Montgomery reduction T = C * 2^(-LOGQ) mod q. It is meant for
// NTT-friendly moduli q = qH * 2^LOGQH + 1, with
// qH = 2^LOGQH - 2^K1 - 2^K2 (+ 2^K3).
// The product m*qH is built from shifts and adds only, so no multipliers are
// used. The reduction runs two word iterations of width w = LOGQH.
//
// Flow control: there is no valid/ready pair. Every clock cycle carries a new
// datum, and qH/K1/K2/K3 travel down the pipeline alongside their C. The
// modulus can therefore change on any cycle.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; clears every pipeline register
//   qH   : upper word of q, where q = {qH, LOGQH'b0} + 1
//   C    : 2*LOGQ-bit value to reduce (C < q * 2^LOGQ)
//   K1   : shift amount of the first subtracted term
//   K2   : shift amount of the second subtracted term
//   K3   : shift amount of the added term (used when USE_K3 != 0)
//   T    : reduced result; in [0,q) when CORRECT != 0
//
// Stages (each is registered when its FF_* is nonzero, else combinational)
//   IN    : capture inputs
//   SHF0  : P0 = m0*qH
//   SUB0  : X1 = (X0 >>> w) - P0
//   SHF1  : P1 = m1*qH
//   SUB1  : X2 = (X1 >>> w) - P1
//   SUM   : X2, X2+q, X2-q and the range flags
//   OUT   : select the result and drive T
// LAT is the sum of the FF_* enables.
// ---------------------------------------------------------------------------
module montgomery_shift_reduce #(
   parameter int LOGQ    = 64,
   parameter int LOGQH   = 32,
   parameter int CORRECT = 1,
   parameter int FF_IN   = 1,
   parameter int FF_SHF0 = 1,
   parameter int FF_SUB0 = 1,
   parameter int FF_SHF1 = 1,
   parameter int FF_SUB1 = 1,
   parameter int FF_SUM  = 1,
   parameter int FF_OUT  = 1,
   parameter int USE_K3  = 1,
   parameter int LOGK1   = 5,
   parameter int LOGK2   = 5,
   parameter int LOGK3   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LOGQH-1:0]    qH,
   input  logic [2*LOGQ-1:0]   C,
   input  logic [LOGK1-1:0]    K1,
   input  logic [LOGK2-1:0]    K2,
   input  logic [LOGK3-1:0]    K3,
   output logic [LOGQ-1:0]     T
);

   localparam int LAT = FF_IN + FF_SHF0 + FF_SUB0 + FF_SHF1 + FF_SUB1 + FF_SUM + FF_OUT;

   // Two guard bits above 2*LOGQ let the intermediate X values go negative.
   localparam int XW = 2*LOGQ + 2;

   // m*qH expressed as shifts of m:
   //   (m<<w) - (m<<K1) - (m<<K2) [+ (m<<K3)]
   function automatic logic signed [XW-1:0] mul_qh(
      input logic [LOGQH-1:0] m,
      input logic [LOGK1-1:0] k1,
      input logic [LOGK2-1:0] k2,
      input logic [LOGK3-1:0] k3
   );
      logic signed [XW-1:0] me;
      logic signed [XW-1:0] add3;
      me   = $signed({{(XW-LOGQH){1'b0}}, m});
      add3 = (USE_K3 != 0) ? (me << k3) : '0;
      return (me << LOGQH) - (me << k1) - (me << k2) + add3;
   endfunction

   // ---------------- IN ----------------
   logic [2*LOGQ-1:0] s0_c;
   logic [LOGQH-1:0]  s0_qh;
   logic [LOGK1-1:0]  s0_k1;
   logic [LOGK2-1:0]  s0_k2;
   logic [LOGK3-1:0]  s0_k3;

   if (FF_IN != 0) begin : g_in_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s0_c  <= '0;
            s0_qh <= '0;
            s0_k1 <= '0;
            s0_k2 <= '0;
            s0_k3 <= '0;
         end else begin
            s0_c  <= C;
            s0_qh <= qH;
            s0_k1 <= K1;
            s0_k2 <= K2;
            s0_k3 <= K3;
         end
      end
   end else begin : g_in_comb
      assign s0_c  = C;
      assign s0_qh = qH;
      assign s0_k1 = K1;
      assign s0_k2 = K2;
      assign s0_k3 = K3;
   end

   // ---------------- SHF0 ----------------
   logic signed [XW-1:0] x0, p0;
   assign x0 = $signed({2'b00, s0_c});
   assign p0 = mul_qh(s0_c[LOGQH-1:0], s0_k1, s0_k2, s0_k3);

   logic signed [XW-1:0] s1_x, s1_p;
   logic [LOGQH-1:0]     s1_qh;
   logic [LOGK1-1:0]     s1_k1;
   logic [LOGK2-1:0]     s1_k2;
   logic [LOGK3-1:0]     s1_k3;

   if (FF_SHF0 != 0) begin : g_shf0_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s1_x  <= '0;
            s1_p  <= '0;
            s1_qh <= '0;
            s1_k1 <= '0;
            s1_k2 <= '0;
            s1_k3 <= '0;
         end else begin
            s1_x  <= x0;
            s1_p  <= p0;
            s1_qh <= s0_qh;
            s1_k1 <= s0_k1;
            s1_k2 <= s0_k2;
            s1_k3 <= s0_k3;
         end
      end
   end else begin : g_shf0_comb
      assign s1_x  = x0;
      assign s1_p  = p0;
      assign s1_qh = s0_qh;
      assign s1_k1 = s0_k1;
      assign s1_k2 = s0_k2;
      assign s1_k3 = s0_k3;
   end

   // ---------------- SUB0 ----------------
   // X - m*q is an exact multiple of 2^w because q == 1 mod 2^w. Dividing it
   // by 2^w is therefore the floor shift of X minus m*qH.
   logic signed [XW-1:0] x1;
   assign x1 = (s1_x >>> LOGQH) - s1_p;

   logic signed [XW-1:0] s2_x;
   logic [LOGQH-1:0]     s2_qh;
   logic [LOGK1-1:0]     s2_k1;
   logic [LOGK2-1:0]     s2_k2;
   logic [LOGK3-1:0]     s2_k3;

   if (FF_SUB0 != 0) begin : g_sub0_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s2_x  <= '0;
            s2_qh <= '0;
            s2_k1 <= '0;
            s2_k2 <= '0;
            s2_k3 <= '0;
         end else begin
            s2_x  <= x1;
            s2_qh <= s1_qh;
            s2_k1 <= s1_k1;
            s2_k2 <= s1_k2;
            s2_k3 <= s1_k3;
         end
      end
   end else begin : g_sub0_comb
      assign s2_x  = x1;
      assign s2_qh = s1_qh;
      assign s2_k1 = s1_k1;
      assign s2_k2 = s1_k2;
      assign s2_k3 = s1_k3;
   end

   // ---------------- SHF1 ----------------
   logic signed [XW-1:0] p1;
   assign p1 = mul_qh(s2_x[LOGQH-1:0], s2_k1, s2_k2, s2_k3);

   logic signed [XW-1:0] s3_x, s3_p;
   logic [LOGQH-1:0]     s3_qh;

   if (FF_SHF1 != 0) begin : g_shf1_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s3_x  <= '0;
            s3_p  <= '0;
            s3_qh <= '0;
         end else begin
            s3_x  <= s2_x;
            s3_p  <= p1;
            s3_qh <= s2_qh;
         end
      end
   end else begin : g_shf1_comb
      assign s3_x  = s2_x;
      assign s3_p  = p1;
      assign s3_qh = s2_qh;
   end

   // ---------------- SUB1 ----------------
   logic signed [XW-1:0] x2;
   assign x2 = (s3_x >>> LOGQH) - s3_p;

   logic signed [XW-1:0] s4_x;
   logic [LOGQH-1:0]     s4_qh;

   if (FF_SUB1 != 0) begin : g_sub1_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s4_x  <= '0;
            s4_qh <= '0;
         end else begin
            s4_x  <= x2;
            s4_qh <= s3_qh;
         end
      end
   end else begin : g_sub1_comb
      assign s4_x  = x2;
      assign s4_qh = s3_qh;
   end

   // ---------------- SUM ----------------
   // X2 lies in (-q, q). Only the low LOGQ bits of each candidate are needed.
   // The full-width sign and compare are reduced to two flags.
   logic signed [XW-1:0] q_ext;
   logic [LOGQ-1:0]      sum_pq, sum_mq;
   logic                 x2_neg, x2_ge;

   assign q_ext  = $signed({{(XW-LOGQ){1'b0}}, s4_qh, {(LOGQH-1){1'b0}}, 1'b1});
   assign sum_pq = s4_x[LOGQ-1:0] + q_ext[LOGQ-1:0];
   assign sum_mq = s4_x[LOGQ-1:0] - q_ext[LOGQ-1:0];
   assign x2_neg = s4_x[XW-1];
   assign x2_ge  = (s4_x >= q_ext);

   logic [LOGQ-1:0] s5_x, s5_pq, s5_mq;
   logic            s5_neg, s5_ge;

   if (FF_SUM != 0) begin : g_sum_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s5_x   <= '0;
            s5_pq  <= '0;
            s5_mq  <= '0;
            s5_neg <= 1'b0;
            s5_ge  <= 1'b0;
         end else begin
            s5_x   <= s4_x[LOGQ-1:0];
            s5_pq  <= sum_pq;
            s5_mq  <= sum_mq;
            s5_neg <= x2_neg;
            s5_ge  <= x2_ge;
         end
      end
   end else begin : g_sum_comb
      assign s5_x   = s4_x[LOGQ-1:0];
      assign s5_pq  = sum_pq;
      assign s5_mq  = sum_mq;
      assign s5_neg = x2_neg;
      assign s5_ge  = x2_ge;
   end

   // ---------------- OUT ----------------
   logic [LOGQ-1:0] t_sel;
   always_comb begin
      t_sel = s5_x;
      if (CORRECT != 0) begin
         if (s5_neg)
            t_sel = s5_pq;
         else if (s5_ge)
            t_sel = s5_mq;
      end
   end

   if (FF_OUT != 0) begin : g_out_ff
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            T <= '0;
         else
            T <= t_sel;
      end
   end else begin : g_out_comb
      assign T = t_sel;
   end

endmodule

// File: tb/tb_montgomery_shift_reduce.sv
// tb_montgomery_shift_reduce
// Directed and randomized bench for montgomery_shift_reduce with the default
// parameters (LAT = 7, CORRECT = 1, USE_K3 = 1).
// Expected results are kept in a queue with one entry per cycle.
module tb_montgomery_shift_reduce;

   localparam int               LAT    = 7;
   localparam logic [31:0]      REF_QH = 32'hb0400000;
   localparam logic [4:0]       REF_K1 = 5'd30;
   localparam logic [4:0]       REF_K2 = 5'd28;
   localparam logic [4:0]       REF_K3 = 5'd22;
   localparam logic [127:0]     REF_C  = 128'h7958100000000001607ffffffffffffd;
   localparam logic [63:0]      REF_T  = 64'h2b5fc00000000003;
   localparam logic [63:0]      T_ONE  = 64'h7958100000000000;
   localparam logic [127:0]     C_QR   = 128'hb0400000000000010000000000000000;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  qh;
   logic [127:0] c;
   logic [4:0]   k1, k2, k3;
   logic [63:0]  t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q[$];
   string       tag_q[$];

   montgomery_shift_reduce dut (
      .clk (clk),
      .rst (rst),
      .qH  (qh),
      .C   (c),
      .K1  (k1),
      .K2  (k2),
      .K3  (k3),
      .T   (t)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // T = C * 2^-64 mod q. C is first reduced mod q, then divided by 2
   // sixty-four times. Each halving adds q first whenever the value is odd.
   function automatic logic [63:0] ref_model(input logic [127:0] cv, input logic [31:0] qv);
      logic [191:0] q, x;
      q = {128'd0, qv, 32'd0} + 192'd1;
      x = {64'd0, cv} % q;
      for (int i = 0; i < 64; i++) begin
         if (x[0])
            x = x + q;
         x = x >> 1;
      end
      return x[63:0];
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: T=%h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock cycle. Retire the oldest expectation, then apply a new input.
   task automatic cycle(input string tag, input logic [127:0] cv, input logic [31:0] qv,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic [63:0] ev);
      @(negedge clk);
      if (exp_q.size() >= LAT)
         check(tag_q.pop_front(), t, exp_q.pop_front());
      c  = cv;
      qh = qv;
      k1 = a;
      k2 = b;
      k3 = d;
      exp_q.push_back(ev);
      tag_q.push_back(tag);
   endtask

   task automatic ref_cycle(input string tag, input logic [127:0] cv, input logic [63:0] ev);
      cycle(tag, cv, REF_QH, REF_K1, REF_K2, REF_K3, ev);
   endtask

   // Release reset on a falling edge. Every in-flight stage holds zero, which
   // must come out as T = 0.
   task automatic release_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      tag_q.delete();
      for (int i = 0; i < LAT; i++) begin
         exp_q.push_back(64'd0);
         tag_q.push_back(tag);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b0;
      c   = '0;
      qh  = REF_QH;
      k1  = REF_K1;
      k2  = REF_K2;
      k3  = REF_K3;

      #3;
      check("reset_state", t, 64'd0);
      repeat (2) begin
         @(negedge clk);
         check("reset_held", t, 64'd0);
      end
      release_reset("post_init");

      // Reference vector held for one cycle, then zeros.
      ref_cycle("ref_vector", REF_C, REF_T);
      repeat (3) ref_cycle("zero_after_ref", 128'd0, 64'd0);

      // Negative X2 (+q correction), X2 = q (-q correction), zero.
      ref_cycle("c_one", 128'd1, T_ONE);
      ref_cycle("c_q_r", C_QR, 64'd0);
      ref_cycle("c_zero", 128'd0, 64'd0);

      // Back-to-back: the three results must appear on consecutive cycles.
      ref_cycle("b2b_one", 128'd1, T_ONE);
      ref_cycle("b2b_ref", REF_C, REF_T);
      ref_cycle("b2b_zero", 128'd0, 64'd0);

      // Random moduli and values. The modulus changes every cycle.
      for (int i = 0; i < 48; i++) begin
         logic [4:0]   a, b, d;
         logic [31:0]  qv;
         logic [191:0] qf, cf;
         a  = 5'($urandom_range(24, 30));
         b  = 5'($urandom_range(16, 32'(a) - 1));
         d  = 5'($urandom_range(1, 32'(b) - 1));
         qv = 32'((64'd1 << 32) - (64'd1 << a) - (64'd1 << b) + (64'd1 << d));
         qf = {128'd0, qv, 32'd0} + 192'd1;
         if (i % 6 == 5)
            cf = (qf << 64) - 192'd1;
         else
            cf = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % (qf << 64);
         cycle("random", cf[127:0], qv, a, b, d, ref_model(cf[127:0], qv));
      end

      // Mid-stream reset with two inputs in flight.
      ref_cycle("flushed_a", REF_C, REF_T);
      ref_cycle("flushed_b", 128'd1, T_ONE);
      #2;
      rst = 1'b0;
      c   = '0;
      #1;
      check("rst_async", t, 64'd0);
      repeat (2) begin
         @(negedge clk);
         check("rst_mid_held", t, 64'd0);
      end
      release_reset("no_stale");

      // A fresh reference input after reset.
      ref_cycle("ref_after_rst", REF_C, REF_T);
      ref_cycle("one_after_rst", 128'd1, T_ONE);

      // Drain the pipeline.
      repeat (LAT + 1) ref_cycle("drain", 128'd0, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
